// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared constants for the RV32I writeback stage.
package riscv_wb_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    REGIN_ALU = 2'b00,
    REGIN_IMM = 2'b01,
    REGIN_PC4 = 2'b10,
    REGIN_RSV = 2'b11
  } regin_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it according to the load funct3.
module wb_load_align #(
  parameter int XLEN = riscv_wb_pkg::XLEN
) (
  input  logic [XLEN-1:0] drdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data
);
  import riscv_wb_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: halfword lane uses only the upper offset bit.
  always_comb begin
    byte_sel = drdata[{byte_off, 3'b000} +: 8];
    half_sel = drdata[{byte_off[1], 4'b0000} +: 16];
  end

  // Extension by load type; unknown funct3 values fall back to a full word.
  always_comb begin
    load_data = drdata;
    case (funct3)
      F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = drdata;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback source select, 32x32 architectural register file
// with two combinational read ports, commit mirror for forwarding, and a
// 64-bit retired-instruction counter.
// Optional macro REGFILE_BYPASS_EN: read ports return the value being
// committed in the same cycle (write-through). Without it they return the
// stored, pre-commit value.
module wb_regfile #(
  parameter int XLEN  = riscv_wb_pkg::XLEN,
  parameter int NREGS = riscv_wb_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic [1:0]      regin,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] drdata,
  input  logic [XLEN-1:0] immgen,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] daddr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [63:0]     instret
);
  import riscv_wb_pkg::*;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] load_data;
  logic [63:0]     instret_q;
  logic [2:0]      funct3;
  logic            unused_bits;

  assign wb_rd       = idata[11:7];
  assign funct3      = idata[14:12];
  assign instret     = instret_q;
  assign unused_bits = ^{idata[31:15], idata[6:0], daddr[XLEN-1:2]};

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .drdata    (drdata),
    .byte_off  (daddr[1:0]),
    .funct3    (funct3),
    .load_data (load_data)
  );

  // Commit enable and writeback value; load data overrides the regin select.
  always_comb begin
    wb_we   = wb_valid & regwrite & (wb_rd != 5'd0);
    wb_data = alu_out;
    if (memtoreg) begin
      wb_data = load_data;
    end else begin
      case (regin)
        REGIN_IMM: wb_data = immgen;
        REGIN_PC4: wb_data = pc_plus4;
        default:   wb_data = alu_out;
      endcase
    end
  end

  // Register array: cleared on reset, written on commit; x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports: x0 reads zero, optional same-cycle write-through.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && (rs1_addr == wb_rd)) rs1_data = wb_data;
    if (wb_we && (rs2_addr == wb_rd)) rs2_data = wb_data;
`endif
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  // Retired-instruction counter: every valid slot counts, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (wb_valid) begin
      instret_q <= instret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile. Stimulus pushes expected
// outputs from a behavioural model; a monitor pops and compares them.
// Honours REGFILE_BYPASS_EN in the same way as the design.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        memtoreg = 1'b0;
  logic        regwrite = 1'b0;
  logic [1:0]  regin = 2'b00;
  logic [31:0] alu_out = '0;
  logic [31:0] drdata = '0;
  logic [31:0] immgen = '0;
  logic [31:0] pc_plus4 = '0;
  logic [31:0] idata = '0;
  logic [31:0] daddr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [63:0] instret;

  typedef struct {
    logic        rst;
    logic        v;
    logic        mtr;
    logic        rw;
    logic [1:0]  rg;
    logic [31:0] alu;
    logic [31:0] dr;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [63:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  logic [63:0] model_ir;
  int          checks = 0;
  int          errors = 0;

  wb_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .regin    (regin),
    .alu_out  (alu_out),
    .drdata   (drdata),
    .immgen   (immgen),
    .pc_plus4 (pc_plus4),
    .idata    (idata),
    .daddr    (daddr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .instret  (instret)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Load extraction by plain shifting and masking of the memory word.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] word,
                                             input int off);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  function automatic stim_t base_stim();
    stim_t s;
    s.rst = 1'b1; s.v = 1'b1; s.mtr = 1'b0; s.rw = 1'b0; s.rg = 2'b00;
    s.alu = $urandom(); s.dr = $urandom(); s.imm = $urandom(); s.pc4 = $urandom();
    s.rd = 5'd0; s.f3 = 3'b010; s.off = 2'b00; s.a1 = 5'd0; s.a2 = 5'd0;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("wb_we", {63'd0, wb_we}, {63'd0, e.we});
    check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
    check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
    check("rs1_data", {32'd0, rs1_data}, {32'd0, e.r1});
    check("rs2_data", {32'd0, rs2_data}, {32'd0, e.r2});
    check("instret", instret, e.ir);
  endtask

  // Drive one cycle at the falling edge, queue the expected response, then
  // advance the model to the state after the following rising edge.
  task automatic applyStimulus(input stim_t s);
    exp_t        e;
    logic [31:0] r;
    logic [31:0] value;
    @(negedge clk);
    rst_n = s.rst;
    if (!s.rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_ir = '0;
    end
    r = $urandom();
    wb_valid = s.v; memtoreg = s.mtr; regwrite = s.rw; regin = s.rg;
    alu_out = s.alu; drdata = s.dr; immgen = s.imm; pc_plus4 = s.pc4;
    idata = {r[31:15], s.f3, s.rd, r[6:0]};
    r = $urandom();
    daddr = {r[31:2], s.off};
    rs1_addr = s.a1; rs2_addr = s.a2;

    if (s.mtr)              value = load_value(s.f3, s.dr, int'(s.off));
    else if (s.rg == 2'd1)  value = s.imm;
    else if (s.rg == 2'd2)  value = s.pc4;
    else                    value = s.alu;
    e.we   = s.v && s.rw && (s.rd != 0);
    e.rd   = s.rd;
    e.data = value;
    e.r1   = (s.a1 == 0) ? 32'd0 : (BYPASS && e.we && s.a1 == s.rd) ? value : model_regs[s.a1];
    e.r2   = (s.a2 == 0) ? 32'd0 : (BYPASS && e.we && s.a2 == s.rd) ? value : model_regs[s.a2];
    e.ir   = model_ir;
    exp_q.push_back(e);

    if (s.rst) begin
      if (e.we) model_regs[s.rd] = value;
      if (s.v)  model_ir = model_ir + 64'd1;
    end
  endtask

  // Monitor: compare every queued expectation shortly before the rising edge.
  always begin
    @(negedge clk);
    #4;
    while (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    stim_t s;
    logic [2:0] lf3 [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0] loff [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_ir = '0;

    // Initial reset.
    s = base_stim(); s.rst = 1'b0; s.v = 1'b0;
    applyStimulus(s);
    applyStimulus(s);

    // Write x5, then assert reset mid-cycle with a pending commit.
    s = base_stim(); s.rw = 1'b1; s.rd = 5'd5; s.alu = 32'h1234; s.a1 = 5'd5;
    applyStimulus(s);
    s = base_stim(); s.a1 = 5'd5;
    applyStimulus(s);
    s = base_stim(); s.rst = 1'b0; s.rw = 1'b1; s.rd = 5'd9; s.alu = 32'h99; s.a1 = 5'd5;
    applyStimulus(s);
    s = base_stim(); s.rw = 1'b1; s.rd = 5'd9; s.alu = 32'h77; s.a1 = 5'd9; s.a2 = 5'd5;
    applyStimulus(s);
    s = base_stim(); s.a1 = 5'd9; s.a2 = 5'd5;
    applyStimulus(s);

    // Load extraction on a fixed memory word.
    for (int i = 0; i < 6; i++) begin
      s = base_stim(); s.mtr = 1'b1; s.rw = 1'b1; s.rd = 5'd10; s.dr = 32'h80FF_7F01;
      s.f3 = lf3[i]; s.off = loff[i]; s.a1 = 5'd10; s.rg = (i == 5) ? 2'd2 : 2'd0;
      applyStimulus(s);
    end

    // Source select: immediate, then PC+4.
    s = base_stim(); s.rw = 1'b1; s.rg = 2'd1; s.imm = 32'hABCD_E000; s.rd = 5'd7;
    applyStimulus(s);
    s = base_stim(); s.rw = 1'b1; s.rg = 2'd2; s.pc4 = 32'h104; s.rd = 5'd8; s.a1 = 5'd7;
    applyStimulus(s);
    s = base_stim(); s.a1 = 5'd8; s.a2 = 5'd7; s.rg = 2'd3;
    applyStimulus(s);

    // x0 writes and bubbles.
    s = base_stim(); s.rw = 1'b1; s.rd = 5'd0; s.alu = 32'hDEAD;
    applyStimulus(s);
    s = base_stim(); s.v = 1'b0; s.rw = 1'b1; s.rd = 5'd11; s.alu = 32'h1111; s.a1 = 5'd11;
    applyStimulus(s);
    s = base_stim(); s.v = 1'b0; s.a1 = 5'd11; s.a2 = 5'd0;
    applyStimulus(s);

    // Same-cycle read of the register being written, then the next cycle.
    s = base_stim(); s.rw = 1'b1; s.rd = 5'd3; s.alu = 32'h55; s.a1 = 5'd3; s.a2 = 5'd3;
    applyStimulus(s);
    s = base_stim(); s.a1 = 5'd3; s.a2 = 5'd3;
    applyStimulus(s);

    // Counter: valid slots separated by bubbles.
    for (int i = 0; i < 6; i++) begin
      s = base_stim(); s.v = (i % 2 == 0); s.a1 = 5'd3;
      applyStimulus(s);
    end

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      s = base_stim();
      s.v   = ($urandom_range(0, 9) != 0);
      s.mtr = ($urandom_range(0, 3) == 0);
      s.rw  = ($urandom_range(0, 3) != 0);
      s.rg  = 2'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 7));
      s.f3  = 3'($urandom_range(0, 7));
      s.off = 2'($urandom_range(0, 3));
      s.a1  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      s.a2  = 5'($urandom_range(0, 7));
      applyStimulus(s);
    end

    @(negedge clk);
    #6;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the pipelined RV32I CPU, at the consuming end of the MEM/WB pipeline register. Each cycle it takes the registered MEM/WB bundle and selects the writeback value: ALU result, aligned and extended load data, immediate, or PC+4. It commits that value to a 32×32 register file and exposes two combinational read ports to the ID stage. It also mirrors the commit (rd, data, enable) for the forwarding unit and maintains a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count; x0 hardwired to zero

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  MEM/WB slot holds a real instruction, not a bubble
- memtoreg  in  1  select load data; overrides regin
- regwrite  in  1  instruction writes rd
- regin  in  2  source select: 00 ALU, 01 immgen, 10 PC+4, 11 reserved (treated as ALU)
- alu_out  in  XLEN  ALU result
- drdata  in  XLEN  raw data-memory read word
- immgen  in  XLEN  immediate (LUI)
- pc_plus4  in  XLEN  link address (JAL/JALR)
- idata  in  32  instruction word; rd = idata[11:7], funct3 = idata[14:12]
- daddr  in  XLEN  data address; only daddr[1:0] used
- rs1_addr, rs2_addr  in  5  ID-stage read addresses
- rs1_data, rs2_data  out  XLEN  read data, combinational
- wb_we  out  1  commit enable this cycle
- wb_rd  out  5  commit destination
- wb_data  out  XLEN  commit value
- instret  out  64  retired-instruction count

## Operation
- Commit enable: wb_we = wb_valid & regwrite & (rd != 0).
- Writeback source: memtoreg=1 selects the load-extracted value; otherwise regin selects.
- Load extraction, byte offset b = daddr[1:0]:
  - funct3 000 LB: sign-extend byte b.
  - 100 LBU: zero-extend byte b.
  - 001 LH: sign-extend halfword daddr[1]; daddr[0] ignored.
  - 101 LHU: zero-extend halfword daddr[1]; daddr[0] ignored.
  - 010 LW and all other funct3 values: full word, address bits ignored.
- Register file:
  - Written at the rising clk edge when wb_we=1.
  - Writes to x0 are dropped; reads of x0 return 0.
- instret: +1 on every clock edge with wb_valid=1, independent of regwrite. Wraps from 2^64−1 to 0.
- wb_valid=0: no write and no count. wb_we is forced to 0; wb_rd and wb_data still carry the decoded values.

## Timing
- Reset (rst_n low, asynchronous): all 31 writable registers clear to 0 and instret clears to 0. rs*_data then read 0. wb_* follow their inputs combinationally.
- Reset asserted mid-cycle aborts any pending commit. The first commit occurs at the first rising edge after rst_n deasserts.
- wb_we, wb_rd, wb_data are combinational from the inputs: 0-cycle latency to the forwarding unit.
- Committed value is visible on rs*_data from the cycle after the commit edge (1-cycle write-to-read latency).
- Simultaneous read and write of the same register: see Configuration.
- Both read ports may address the same register; each returns identical data.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: if wb_we=1 and rs1_addr (or rs2_addr) == wb_rd, that port returns wb_data in the same cycle (write-through). rs*_addr=0 always returns 0.
- Undefined: the port returns the pre-commit stored value. The hazard unit must cover the WB→ID distance by stall or forwarding.

## Structure
- Shared package riscv_wb_pkg:
  - XLEN, NREGS.
  - regin encodings REGIN_ALU/REGIN_IMM/REGIN_PC4.
  - load funct3 constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU.
- One sub-module wb_load_align (combinational): drdata, daddr[1:0], funct3 → extended XLEN value.
- Register array, source mux, bypass and instret counter live in wb_regfile.

## Test plan
- Reset: pulse rst_n low mid-cycle after writing x5=0x1234 → rs1_data(x5)=0, instret=0 immediately; first commit occurs only after rst_n deasserts.
- Load extension: drdata=0x80FF7F01. LB at b=1 → 0x0000007F; LB at b=3 → 0xFFFFFF80; LBU at b=2 → 0x000000FF; LH with daddr[1:0]=10 → 0xFFFF80FF; LHU with daddr[1:0]=01 → 0x00007F01; LW → 0x80FF7F01.
- Source select: regin=01, immgen=0xABCDE000, rd=7 → x7=0xABCDE000 next cycle. regin=10, pc_plus4=0x104 → 0x104. memtoreg=1 with regin=10 → load data wins.
- x0 and bubbles: write rd=0 value 0xDEAD → wb_we=0, x0 reads 0. wb_valid=0 with regwrite=1 → no write, instret unchanged.
- Bypass: write x3=0x55 while rs1_addr=rs2_addr=3 → 0x55 same cycle with REGFILE_BYPASS_EN, old value without it. Both builds read 0x55 the next cycle.
- instret wrap: force count to 0xFFFF_FFFF_FFFF_FFFF, one valid cycle → 0. Three valid cycles separated by bubbles → +3.
